cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Shares the single common data bus (CDB) among the functional units that complete instructions issued from the ALU and load/store reservation stations. Each requester posts a completed result (ROB tag and value) into a private FIFO. A round-robin arbiter grants one result per cycle, and the winner is driven onto the registered `cdb` output. That output feeds every reservation station, the map table and the ROB.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters. Index 0 = ALU, 1 = MUL, 2 = LD/ST.
- `FIFO_DEPTH`, default 2: entries per requester FIFO. Must be a power of 2 and at least 1.

Ports:
- `clk`, input, 1: rising-edge clock.
- `reset`, input, 1: synchronous, active-low reset.
- `flush`, input, 1: synchronous squash, e.g. on mispredict.
- `req_valid`, input, `[NUM_REQ]`: requester i presents a result.
- `req_data`, input, `CDB_DATA [NUM_REQ]`: `{rob_tag, value}` per requester.
- `req_ready`, output, `[NUM_REQ]`: FIFO i accepts data this cycle.
- `cdb`, output, `CDB_DATA`: broadcast result. All-zero means idle.
- `cdb_src`, output, `$clog2(NUM_REQ)`: index of the requester now on `cdb`.

## Operation
- ROB tag 0 is reserved as "no broadcast". A request with `rob_tag == 0` is illegal, and the bench asserts it never occurs.
- Enqueue: FIFO i pushes `req_data[i]` at the clock edge when `req_valid[i] && req_ready[i]`.
- `req_ready[i] = (count[i] != FIFO_DEPTH)`. It is computed from the registered count only. A full FIFO rejects a push even in a cycle where it is also being popped.
- Arbitration is combinational over the non-empty FIFO heads. It searches from `rr_ptr` upward, modulo `NUM_REQ`, and the first non-empty FIFO wins.
- On a grant:
  - The winner's head is popped.
  - `cdb <= head` and `cdb_src <= winner`.
  - `rr_ptr <= (winner + 1) % NUM_REQ`.
- With no non-empty FIFO: `cdb <= 0`, `cdb_src <= 0`, and `rr_ptr` holds.
- A simultaneous push and pop on the same non-full FIFO leaves its count unchanged and its order preserved.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count ranges over 0..`FIFO_DEPTH`.
- `flush`:
  - All FIFO counts and pointers go to 0 and `cdb` goes to 0 at the edge.
  - Pushes in the flush cycle are discarded.
  - `rr_ptr` holds.
- `reset` low at any edge forces all state to its reset value, regardless of `flush` or `req_valid`. Reset has priority over flush.

## Timing
- Reset values: `cdb = 0`, `cdb_src = 0`, `req_ready = all 1`, `rr_ptr = 0`, all FIFOs empty.
- Latency:
  - A request accepted at edge E is at its FIFO head in the cycle after E.
  - If it wins, `cdb` shows it after edge E+1.
  - Minimum latency is therefore 2 edges from `req_valid` to broadcast.
- `cdb` is valid for exactly one cycle per grant. It is never held or repeated.
- Throughput is 1 broadcast per cycle total. No requester waits more than `NUM_REQ-1` grants once it is at its FIFO head.
- `req_ready` depends only on registered state, so there is no combinational path from `req_valid` to `req_ready`.

## Structure
- `CDB_DATA` and `ROB_TAG_LEN` are used as already defined in the shared package (`sys_defs`). Add `CDB_REQ_ALU`, `CDB_REQ_MUL` and `CDB_REQ_LDST` index constants there.
- Sub-module `cdb_req_fifo` holds one parameterised FIFO with:
  - ports: push, pop, flush, full, empty, head;
  - the arbiter instantiates it `NUM_REQ` times via generate.
- The round-robin pick is a function inside `cdb_arbiter`.

## Test plan
- Single request: after reset, requester 0 presents tag 3, value 0x11 for 1 cycle.
  - Required: `cdb = {3, 0x11}`, `cdb_src = 0` exactly 2 edges later, then `cdb = 0`.
- Simultaneous requests: all three requesters present tags 1, 2, 3 in the same cycle.
  - Required: broadcasts on consecutive cycles in order tag 1 (src 0), tag 2 (src 1), tag 3 (src 2), then idle.
- Fairness: requesters 0 and 2 each present a new result every cycle for 8 cycles.
  - Required: `cdb_src` alternates 0, 2, 0, 2…
  - Required: no source is granted twice in a row while the other is non-empty.
- Backpressure: hold requester 1 valid with tags 4, 5, 6 while requester 0 continuously occupies the CDB.
  - Required: `req_ready[1]` drops to 0 after 2 accepts.
  - Required: tag 6 is accepted only after a grant pops FIFO 1, and no tag is lost or duplicated.
- Flush: FIFOs hold tags 7, 8, 9 and `flush` is pulsed with tag 10 presented in the same cycle.
  - Required: `cdb = 0` next cycle, and tags 7–10 are never broadcast.
  - Required: a new tag 11 pushed afterwards broadcasts 2 edges later.
- Reset mid-operation: drive `reset` low for 1 edge while FIFOs are non-empty and `cdb` is busy.
  - Required: all outputs return to reset values next cycle, and nothing queued before the reset is broadcast.

Source files
------------

// File: rtl/sys_defs_pkg.sv
// Shared processor definitions: ROB tag width, CDB payload type and
// the fixed requester slots on the common data bus.
package sys_defs;

  localparam int ROB_TAG_LEN = 5;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] rob_tag;
    logic [XLEN-1:0]        value;
  } CDB_DATA;

  localparam int CDB_REQ_ALU  = 0;
  localparam int CDB_REQ_MUL  = 1;
  localparam int CDB_REQ_LDST = 2;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO feeding the CDB arbiter. A full FIFO refuses
// pushes even when it is popped in the same cycle; flush empties it.
module cdb_req_fifo
  import sys_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    flush,
  input  logic    push,
  input  CDB_DATA data,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output CDB_DATA head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  CDB_DATA            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;

  // DEPTH is a power of two, so the natural binary wrap is the modulo wrap.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (DEPTH == 1) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // NOTE: storage is deliberately not reset; a zero count makes stale
  // entries unreachable, and leaving it unreset lets it map to plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per completing unit, round-robin grant
// of one result per cycle onto the registered cdb broadcast.
module cdb_arbiter
  import sys_defs::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 2,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  CDB_DATA [NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output CDB_DATA               cdb,
  output logic [SRC_W-1:0]      cdb_src
);

  typedef struct packed {
    logic             found;
    logic [SRC_W-1:0] idx;
  } pick_t;

  CDB_DATA            heads [NUM_REQ];
  logic [NUM_REQ-1:0] full;
  logic [NUM_REQ-1:0] empty;
  logic [NUM_REQ-1:0] pop;
  logic [SRC_W-1:0]   rr_ptr;
  pick_t              pick;

  // Walk offsets from the far end back to zero so the nearest non-empty
  // requester at or after start is the one left standing.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] avail,
                                    input logic [SRC_W-1:0]   start);
    pick_t p;
    int    c;
    p = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      c = (int'(start) + k) % NUM_REQ;
      if (avail[c]) begin
        p.found = 1'b1;
        p.idx   = SRC_W'(c);
      end
    end
    return p;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
    cdb_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (req_valid[g]),
      .data  (req_data[g]),
      .pop   (pop[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (heads[g])
    );
  end

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    pick = '0;
    pop  = '0;
    pick = rr_pick(~empty, rr_ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      pop[i] = pick.found && (pick.idx == SRC_W'(i));
    end
  end

  assign req_ready = ~full;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cdb     <= '0;
      cdb_src <= '0;
      rr_ptr  <= '0;
    end else if (flush || !pick.found) begin
      cdb     <= '0;
      cdb_src <= '0;
    end else begin
      cdb     <= heads[pick.idx];
      cdb_src <= pick.idx;
      rr_ptr  <= SRC_W'((int'(pick.idx) + 1) % NUM_REQ);
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and randomized bench for cdb_arbiter against a queue-based model
// of the per-requester FIFOs and the round-robin grant rule.
module tb_cdb_arbiter;
  import sys_defs::*;

  localparam int NREQ  = 3;
  localparam int DEPTH = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic               flush;
  logic [NREQ-1:0]    req_valid;
  CDB_DATA [NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  CDB_DATA            cdb;
  logic [1:0]         cdb_src;

  int n_checks = 0;
  int n_pass   = 0;

  CDB_DATA mq [NREQ][$];
  int      rr_m;
  CDB_DATA exp_cdb;
  int      exp_src;

  cdb_arbiter #(.NUM_REQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb       (cdb),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    exp_cdb = '0;
    exp_src = 0;
  endtask

  // One clock: check ready before the edge, advance model, check bus after.
  task automatic step(input string tag);
    logic [NREQ-1:0] rdy;
    int              win;
    bit              found;
    for (int i = 0; i < NREQ; i++) rdy[i] = (mq[i].size() < DEPTH);
    check({tag, "_ready"}, 64'(req_ready), 64'(rdy));
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i]) check({tag, "_tag_nonzero"}, 64'(req_data[i].rob_tag != '0), 64'(1));
    @(posedge clk);
    if (!reset) begin
      clear_model();
      rr_m = 0;
    end else if (flush) begin
      clear_model();
    end else begin
      found = 1'b0;
      win   = 0;
      for (int k = 0; k < NREQ; k++) begin
        int c = (rr_m + k) % NREQ;
        if (!found && mq[c].size() > 0) begin
          found = 1'b1;
          win   = c;
        end
      end
      if (found) begin
        exp_cdb = mq[win].pop_front();
        exp_src = win;
        rr_m    = (win + 1) % NREQ;
      end else begin
        exp_cdb = '0;
        exp_src = 0;
      end
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && rdy[i]) mq[i].push_back(req_data[i]);
    end
    #1;
    check({tag, "_cdb"}, 64'(cdb), 64'(exp_cdb));
    check({tag, "_src"}, 64'(cdb_src), 64'(exp_src));
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_data  = '0;
    flush     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    step("reset");
    check("reset_cdb", 64'(cdb), 64'(0));
    check("reset_src", 64'(cdb_src), 64'(0));
    reset = 1'b1;
  endtask

  initial begin
    int         accepts;
    int         tag0;
    int         idx1;
    int         grants;
    CDB_DATA    seen1 [$];
    logic [4:0] tags1 [3];

    // Bring the DUT out of its unknown power-up state before any checking.
    idle_inputs();
    reset = 1'b0;
    clear_model();
    rr_m = 0;
    repeat (2) @(posedge clk);
    #1;
    check("por_ready", 64'(req_ready), 64'(3'b111));
    do_reset();

    // Single request: broadcast two edges after it is presented, then idle.
    req_valid[CDB_REQ_ALU] = 1'b1;
    req_data[CDB_REQ_ALU]  = {5'd3, 32'h11};
    step("single_push");
    idle_inputs();
    step("single_grant");
    check("single_hit", 64'(cdb), 64'({5'd3, 32'h11}));
    check("single_hit_src", 64'(cdb_src), 64'(0));
    step("single_idle");
    check("single_after", 64'(cdb), 64'(0));

    // Simultaneous requests drain in index order from a fresh pointer.
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) req_data[i] = {5'(i + 1), 32'($urandom)};
    step("simul_push");
    idle_inputs();
    for (int k = 0; k < NREQ; k++) begin
      step("simul_grant");
      check("simul_tag", 64'(cdb.rob_tag), 64'(k + 1));
      check("simul_src", 64'(cdb_src), 64'(k));
    end
    step("simul_idle");
    check("simul_after", 64'(cdb), 64'(0));

    // Fairness: ALU and LD/ST both stream; grants must alternate 0,2,0,2.
    do_reset();
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 3'b101;
      req_data[0] = {5'(1 + c), 32'($urandom)};
      req_data[2] = {5'(16 + c), 32'($urandom)};
      step("fair");
      if (c > 0) begin
        check("fair_src", 64'(cdb_src), 64'((grants % 2) * 2));
        grants++;
      end
    end
    idle_inputs();
    repeat (6) step("fair_drain");

    // Backpressure on MUL while ALU keeps competing for the bus.
    do_reset();
    tags1   = '{5'd4, 5'd5, 5'd6};
    accepts = 0;
    idx1    = 0;
    tag0    = 12;
    for (int c = 0; c < 14; c++) begin
      bit acc0, acc1;
      req_valid[0] = 1'b1;
      req_data[0]  = {5'(tag0), 32'(tag0)};
      req_valid[1] = (idx1 < 3);
      req_data[1]  = (idx1 < 3) ? {tags1[idx1], 32'hA000 + 32'(idx1)} : '0;
      acc0 = mq[0].size() < DEPTH;
      acc1 = req_valid[1] && (mq[1].size() < DEPTH);
      step("bp");
      if (cdb != '0 && cdb_src == 2'd1) seen1.push_back(cdb);
      if (acc0) tag0 = (tag0 >= 30) ? 12 : tag0 + 1;
      if (acc1) begin
        idx1++;
        accepts++;
        if (accepts == 2) check("bp_ready_drop", 64'(req_ready[1]), 64'(0));
      end
    end
    idle_inputs();
    repeat (6) begin
      step("bp_drain");
      if (cdb != '0 && cdb_src == 2'd1) seen1.push_back(cdb);
    end
    check("bp_count", 64'(seen1.size()), 64'(3));
    for (int i = 0; i < 3 && i < seen1.size(); i++)
      check("bp_order", 64'(seen1[i].rob_tag), 64'(tags1[i]));

    // Flush squashes queued results and the push presented alongside it.
    do_reset();
    req_valid = 3'b111;
    req_data[0] = {5'd7, 32'h7};
    req_data[1] = {5'd8, 32'h8};
    req_data[2] = {5'd9, 32'h9};
    step("flush_fill");
    idle_inputs();
    flush        = 1'b1;
    req_valid[0] = 1'b1;
    req_data[0]  = {5'd10, 32'h10};
    step("flush_edge");
    check("flush_cdb", 64'(cdb), 64'(0));
    idle_inputs();
    repeat (3) begin
      step("flush_quiet");
      check("flush_quiet_cdb", 64'(cdb), 64'(0));
    end
    req_valid[0] = 1'b1;
    req_data[0]  = {5'd11, 32'hB};
    step("flush_new_push");
    idle_inputs();
    step("flush_new_grant");
    check("flush_new_cdb", 64'(cdb), 64'({5'd11, 32'hB}));

    // Reset while queues are loaded and the bus is busy.
    do_reset();
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) req_data[i] = {5'(20 + i), 32'($urandom)};
    step("rst_fill1");
    for (int i = 0; i < NREQ; i++) req_data[i] = {5'(23 + i), 32'($urandom)};
    step("rst_fill2");
    check("rst_busy", 64'(cdb.rob_tag), 64'(20));
    reset = 1'b0;
    step("rst_mid");
    check("rst_mid_cdb", 64'(cdb), 64'(0));
    check("rst_mid_src", 64'(cdb_src), 64'(0));
    check("rst_mid_ready", 64'(req_ready), 64'(3'b111));
    reset = 1'b1;
    idle_inputs();
    repeat (4) begin
      step("rst_after");
      check("rst_after_cdb", 64'(cdb), 64'(0));
    end

    // Randomized traffic with occasional flush and reset.
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        req_data[i] = {5'($urandom_range(1, 31)), 32'($urandom)};
      step("rand");
    end
    reset = 1'b1;
    idle_inputs();
    repeat (6) step("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
